// File: rtl/orion_types.sv
// Shared widths and enums for the Orion memory arbiter and its helpers.
package orion_types;

  localparam int ADDRW = 32;
  localparam int XLEN  = 32;
  localparam int MASKW = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

endpackage

// File: rtl/orion_rr_pick.sv
// Two-way grant selector: fixed data-port priority (POLICY=0) or
// round-robin away from the last granted port on a tie (POLICY=1).
module orion_rr_pick
  import orion_types::*;
#(
  parameter int POLICY = 1
) (
  input  logic      req_i_i,
  input  logic      req_d_i,
  input  arb_port_t last_gnt_i,
  output logic      gnt_valid_o,
  output arb_port_t gnt_o
);

  always_comb begin
    gnt_valid_o = req_i_i | req_d_i;
    gnt_o       = PORT_D;
    if (req_i_i && !req_d_i) begin
      gnt_o = PORT_I;
    end else if (req_i_i && req_d_i && (POLICY != 0) && (last_gnt_i == PORT_D)) begin
      gnt_o = PORT_I;
    end
  end

endmodule

// File: rtl/orion_mem_arbiter.sv
// Arbitrates instruction and data requests onto one downstream memory port,
// one outstanding transaction at a time, with a sticky watchdog flag.
module orion_mem_arbiter
  import orion_types::*;
#(
  parameter int ARB_POLICY     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ADDRW-1:0] imem_addr_i,
  input  logic             imem_valid_i,
  output logic [XLEN-1:0]  imem_rdata_o,
  output logic             imem_resp_o,
  input  logic [ADDRW-1:0] dmem_addr_i,
  input  logic [XLEN-1:0]  dmem_wdata_i,
  input  logic [MASKW-1:0] dmem_mask_i,
  input  logic             dmem_we_i,
  input  logic             dmem_valid_i,
  output logic [XLEN-1:0]  dmem_rdata_o,
  output logic             dmem_resp_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic [MASKW-1:0] mem_mask_o,
  output logic             mem_we_o,
  output logic             mem_valid_o,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             mem_resp_i,
  output logic             err_o
);

  // A zero timeout still needs a legal one-bit counter; the watchdog logic is gated off.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  arb_state_t       state_q;
  arb_port_t        last_gnt_q;
  logic [ADDRW-1:0] addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [MASKW-1:0] mask_q;
  logic             we_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q;
  logic             gnt_valid;
  arb_port_t        gnt;

  orion_rr_pick #(.POLICY(ARB_POLICY)) u_pick (
    .req_i_i    (imem_valid_i),
    .req_d_i    (dmem_valid_i),
    .last_gnt_i (last_gnt_q),
    .gnt_valid_o(gnt_valid),
    .gnt_o      (gnt)
  );

  assign cnt_d = cnt_q + CW'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_gnt_q <= PORT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            cnt_q <= '0;
            if (gnt == PORT_D) begin
              state_q <= BUSY_D;
              addr_q  <= dmem_addr_i;
              wdata_q <= dmem_wdata_i;
              mask_q  <= dmem_mask_i;
              we_q    <= dmem_we_i;
            end else begin
              state_q <= BUSY_I;
              addr_q  <= imem_addr_i;
              wdata_q <= '0;
              mask_q  <= '1;
              we_q    <= 1'b0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp_i) begin
            state_q    <= IDLE;
            last_gnt_q <= (state_q == BUSY_I) ? PORT_I : PORT_D;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q != TMAX)) begin
            cnt_q <= cnt_d;
            if (cnt_d == TMAX) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_valid_o  = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_mask_o   = mask_q;
  assign mem_we_o     = we_q;
  assign err_o        = err_q;

  assign imem_resp_o  = (state_q == BUSY_I) && mem_resp_i;
  assign dmem_resp_o  = (state_q == BUSY_D) && mem_resp_i;
  assign imem_rdata_o = imem_resp_o ? mem_rdata_i : '0;
  assign dmem_rdata_o = dmem_resp_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_orion_mem_arbiter.sv
// Scoreboard bench: a round-robin/short-timeout arbiter and a fixed-priority
// arbiter share one stimulus stream; expectations are queued when requests are driven.
module tb_orion_mem_arbiter;
  import orion_types::*;

  typedef struct {
    bit          isD;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;
  logic [ADDRW-1:0] imemAddr, dmemAddr;
  logic imemValid, dmemValid, dmemWe, memResp;
  logic [XLEN-1:0] dmemWdata, memRdata;
  logic [MASKW-1:0] dmemMask;

  logic [XLEN-1:0] o1IRdata, o1DRdata, o1MemWdata, o0IRdata, o0DRdata, o0MemWdata;
  logic [ADDRW-1:0] o1MemAddr, o0MemAddr;
  logic [MASKW-1:0] o1MemMask, o0MemMask;
  logic o1IResp, o1DResp, o1MemWe, o1MemValid, o1Err;
  logic o0IResp, o0DResp, o0MemWe, o0MemValid, o0Err;

  exp_t expQ[$];
  bit   exp0Q[$];
  int   checks = 0;
  int   errors = 0;
  int   waitN;

  always #5 clk = ~clk;

  orion_mem_arbiter #(.ARB_POLICY(1), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .imem_addr_i(imemAddr), .imem_valid_i(imemValid),
    .imem_rdata_o(o1IRdata), .imem_resp_o(o1IResp),
    .dmem_addr_i(dmemAddr), .dmem_wdata_i(dmemWdata), .dmem_mask_i(dmemMask),
    .dmem_we_i(dmemWe), .dmem_valid_i(dmemValid),
    .dmem_rdata_o(o1DRdata), .dmem_resp_o(o1DResp),
    .mem_addr_o(o1MemAddr), .mem_wdata_o(o1MemWdata), .mem_mask_o(o1MemMask),
    .mem_we_o(o1MemWe), .mem_valid_o(o1MemValid),
    .mem_rdata_i(memRdata), .mem_resp_i(memResp), .err_o(o1Err)
  );

  orion_mem_arbiter #(.ARB_POLICY(0)) dutFixed (
    .clk_i(clk), .rst_ni(rstN),
    .imem_addr_i(imemAddr), .imem_valid_i(imemValid),
    .imem_rdata_o(o0IRdata), .imem_resp_o(o0IResp),
    .dmem_addr_i(dmemAddr), .dmem_wdata_i(dmemWdata), .dmem_mask_i(dmemMask),
    .dmem_we_i(dmemWe), .dmem_valid_i(dmemValid),
    .dmem_rdata_o(o0DRdata), .dmem_resp_o(o0DResp),
    .mem_addr_o(o0MemAddr), .mem_wdata_o(o0MemWdata), .mem_mask_o(o0MemMask),
    .mem_we_o(o0MemWe), .mem_valid_o(o0MemValid),
    .mem_rdata_i(memRdata), .mem_resp_i(memResp), .err_o(o0Err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    imemValid = 1'b0; dmemValid = 1'b0; memResp = 1'b0; memRdata = '0;
    imemAddr = '0; dmemAddr = '0; dmemWdata = '0; dmemMask = '0; dmemWe = 1'b0;
    tick(); tick();
    rstN = 1'b1;
  endtask

  task automatic applyStimulus(input bit isD, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] mask, input logic we);
    if (isD) begin
      dmemValid = 1'b1; dmemAddr = addr; dmemWdata = wdata; dmemMask = mask; dmemWe = we;
    end else begin
      imemValid = 1'b1; imemAddr = addr;
    end
  endtask

  task automatic pushExp(input bit isD, input bit isD0, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask, input logic we);
    exp_t e;
    e.isD = isD; e.addr = addr; e.wdata = wdata; e.mask = mask; e.we = we;
    expQ.push_back(e);
    exp0Q.push_back(isD0);
  endtask

  // Waits for the grant, checks downstream fields, then replies after lat cycles.
  task automatic serveTxn(input int lat, input logic [31:0] rd, input bit dropValid, output int n);
    exp_t e;
    bit   d0;
    n = 0;
    while (o1MemValid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("memValid", {31'b0, o1MemValid}, 32'd1);
    checkOutput("sbDepth", {31'b0, (expQ.size() > 0 && exp0Q.size() > 0)}, 32'd1);
    if (expQ.size() == 0 || exp0Q.size() == 0) return;
    e  = expQ.pop_front();
    d0 = exp0Q.pop_front();
    checkOutput("memAddr", o1MemAddr, e.addr);
    checkOutput("memWdata", o1MemWdata, e.wdata);
    checkOutput("memMask", {28'b0, o1MemMask}, {28'b0, e.mask});
    checkOutput("memWe", {31'b0, o1MemWe}, {31'b0, e.we});
    if (dropValid) begin
      imemValid = 1'b0;
      dmemValid = 1'b0;
    end
    repeat (lat) tick();
    memRdata = rd;
    memResp  = 1'b1;
    #1;
    checkOutput("iResp", {31'b0, o1IResp}, {31'b0, !e.isD});
    checkOutput("dResp", {31'b0, o1DResp}, {31'b0, e.isD});
    checkOutput("iRdata", o1IRdata, e.isD ? 32'h0 : rd);
    checkOutput("dRdata", o1DRdata, e.isD ? rd : 32'h0);
    checkOutput("iResp0", {31'b0, o0IResp}, {31'b0, !d0});
    checkOutput("dResp0", {31'b0, o0DResp}, {31'b0, d0});
    tick();
    memResp  = 1'b0;
    memRdata = '0;
    checkOutput("idleValid", {31'b0, o1MemValid}, 32'd0);
    checkOutput("idleValid0", {31'b0, o0MemValid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyReset();
    checkOutput("rstValid", {31'b0, o1MemValid}, 32'd0);
    checkOutput("rstErr", {31'b0, o1Err}, 32'd0);
    checkOutput("rstAddr", o1MemAddr, 32'd0);
    checkOutput("rstMask", {28'b0, o1MemMask}, 32'd0);

    // Stray response while idle must be ignored.
    memResp = 1'b1; memRdata = 32'h55;
    #1;
    checkOutput("strayIResp", {31'b0, o1IResp}, 32'd0);
    checkOutput("strayDResp", {31'b0, o1DResp}, 32'd0);
    checkOutput("strayIRdata", o1IRdata, 32'd0);
    tick();
    memResp = 1'b0; memRdata = '0;
    checkOutput("strayValid", {31'b0, o1MemValid}, 32'd0);

    // Lone instruction read, memory replies one cycle after grant.
    applyStimulus(1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b0);
    pushExp(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b0);
    serveTxn(1, 32'h0000_0013, 1'b0, waitN);
    checkOutput("grantLatency", waitN, 32'd1);
    imemValid = 1'b0;

    // Lone data write.
    applyStimulus(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    pushExp(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    serveTxn(0, 32'h1234_5678, 1'b0, waitN);
    dmemValid = 1'b0;

    // Both held: round-robin D,I,D,I versus fixed D,D,D,D, then I once D drops.
    applyReset();
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_2000, 32'h1111_2222, 4'hF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) pushExp(1'b1, 1'b1, 32'h0000_2000, 32'h1111_2222, 4'hF, 1'b1);
      else            pushExp(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'hF, 1'b0);
      serveTxn(0, 32'hA000_0000 + k, 1'b0, waitN);
      checkOutput("tieGap", waitN, 32'd1);
    end
    dmemValid = 1'b0;
    pushExp(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b0);
    serveTxn(0, 32'hB000_0000, 1'b0, waitN);
    imemValid = 1'b0;

    // Watchdog: err rises after exactly 8 busy cycles and is sticky.
    applyReset();
    applyStimulus(1'b1, 32'h0000_3000, 32'h0, 4'hF, 1'b0);
    pushExp(1'b1, 1'b1, 32'h0000_3000, 32'h0, 4'hF, 1'b0);
    tick();
    checkOutput("wdGrant", {31'b0, o1MemValid}, 32'd1);
    repeat (7) tick();
    checkOutput("wdErrEarly", {31'b0, o1Err}, 32'd0);
    tick();
    checkOutput("wdErrSet", {31'b0, o1Err}, 32'd1);
    repeat (5) tick();
    checkOutput("wdErrHeld", {31'b0, o1Err}, 32'd1);
    checkOutput("wdStillBusy", {31'b0, o1MemValid}, 32'd1);
    checkOutput("wdFixedErr", {31'b0, o0Err}, 32'd0);
    serveTxn(0, 32'hCAFE_0000, 1'b0, waitN);
    dmemValid = 1'b0;
    tick();
    checkOutput("wdErrSticky", {31'b0, o1Err}, 32'd1);

    // Reset in BUSY_D abandons it; a later stray response is ignored.
    applyReset();
    checkOutput("wdErrCleared", {31'b0, o1Err}, 32'd0);
    applyStimulus(1'b1, 32'h0000_4000, 32'h7, 4'h1, 1'b1);
    tick();
    checkOutput("abortBusy", {31'b0, o1MemValid}, 32'd1);
    checkOutput("abortAddr", o1MemAddr, 32'h0000_4000);
    rstN = 1'b0; dmemValid = 1'b0;
    tick();
    rstN = 1'b1;
    checkOutput("abortValid", {31'b0, o1MemValid}, 32'd0);
    memResp = 1'b1; memRdata = 32'h99;
    #1;
    checkOutput("abortDResp", {31'b0, o1DResp}, 32'd0);
    tick();
    memResp = 1'b0; memRdata = '0;
    checkOutput("abortIdle", {31'b0, o1MemValid}, 32'd0);
    applyStimulus(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0);
    pushExp(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b0);
    serveTxn(1, 32'h0000_0042, 1'b0, waitN);
    imemValid = 1'b0;

    // Instruction valid dropped mid-transaction still completes once.
    applyStimulus(1'b0, 32'h0000_0300, 32'h0, 4'h0, 1'b0);
    pushExp(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b0);
    serveTxn(2, 32'h0000_0077, 1'b1, waitN);
    tick();
    checkOutput("dropNoRegrant", {31'b0, o1MemValid}, 32'd0);
    checkOutput("dropNoPulse", {31'b0, o1IResp}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/orion_mem_arbiter.md
ORION_MEM_ARBITER -- requirements
Module: orion_mem_arbiter

Interface
REQ-001 Parameter ARB_POLICY, default 1, meaning 0 = fixed data-port priority, 1 = round-robin on simultaneous requests.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, meaning cycles in a busy state before err_o sets; 0 disables the watchdog.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 imem_addr_i  input  ADDRW  instruction request address.
REQ-006 imem_valid_i  input  1  instruction read request; held until imem_resp_o.
REQ-007 imem_rdata_o  output  XLEN  instruction read data.
REQ-008 imem_resp_o  output  1  one-cycle instruction completion pulse.
REQ-009 dmem_addr_i / dmem_wdata_i / dmem_mask_i / dmem_we_i  input  ADDRW / XLEN / MASKW / 1  data request fields.
REQ-010 dmem_valid_i  input  1  data request; held with stable fields until dmem_resp_o.
REQ-011 dmem_rdata_o  output  XLEN  data read data.
REQ-012 dmem_resp_o  output  1  one-cycle data completion pulse.
REQ-013 mem_addr_o / mem_wdata_o / mem_mask_o / mem_we_o / mem_valid_o  output  ADDRW / XLEN / MASKW / 1 / 1  shared downstream port.
REQ-014 mem_rdata_i  input  XLEN  downstream read data, valid with mem_resp_i.
REQ-015 mem_resp_i  input  1  downstream completion pulse.
REQ-016 err_o  output  1  sticky watchdog timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, BUSY_I, BUSY_D.
REQ-018 IDLE: imem_valid_i only -> BUSY_I; dmem_valid_i only -> BUSY_D; neither -> IDLE.
REQ-019 IDLE with both valid: ARB_POLICY=0 -> BUSY_D; ARB_POLICY=1 -> port not granted last (last_gnt reg, reset value = I, so first tie goes to D).
REQ-020 On IDLE->BUSY_x, request fields SHALL be registered; downstream outputs driven only from these registers.
REQ-021 mem_valid_o SHALL be 1 exactly while in BUSY_I or BUSY_D; first asserted the cycle after the request is seen.
REQ-022 BUSY_I downstream fields: mem_addr_o = latched imem addr, mem_we_o=0, mem_mask_o=all ones, mem_wdata_o=0.
REQ-023 BUSY_D downstream fields: latched dmem addr, wdata, mask, we.
REQ-024 In BUSY_x with mem_resp_i=1: x_resp_o=1 and x_rdata_o=mem_rdata_i combinationally same cycle; next state IDLE; last_gnt <= x.
REQ-025 resp outputs SHALL be 0 in all other cycles; rdata outputs SHALL be 0 when the matching resp is 0.
REQ-026 mem_resp_i in IDLE SHALL be ignored (no resp pulse, no state change).
REQ-027 Request valid dropped mid-transaction: transaction SHALL still complete and pulse resp; no abort.
REQ-028 Minimum latency: request cycle N, mem_valid_o at N+1, resp at N+1 if memory replies same cycle; one IDLE cycle between transactions (max one grant per 2 cycles).
REQ-029 Watchdog counter SHALL clear on entry to BUSY_x, increment each BUSY cycle without mem_resp_i; reaching TIMEOUT_CYCLES sets err_o; FSM keeps waiting.
REQ-030 Counter width $clog2(TIMEOUT_CYCLES+1); counter SHALL saturate, never wrap.

Reset
REQ-031 rst_ni=0 at a clock edge SHALL force IDLE, last_gnt=I, counter=0, err_o=0, latched fields=0, all outputs 0.
REQ-032 Reset mid-transaction SHALL abandon it; a later mem_resp_i lands in IDLE and is ignored per REQ-026.

Structure
REQ-033 ADDRW, XLEN, MASKW SHALL come from orion_types; arb_state_t enum and arb_port_t (I/D) SHALL be added to orion_types.
REQ-034 One sub-module natural: orion_rr_pick (2-way round-robin/fixed selector from two valids and last_gnt); everything else flat.

Verification
REQ-035 Lone I read addr 0x8000_0000, memory replies 1 cycle later with 0x0000_0013 -> mem_we_o=0, mask=all ones, imem_resp_o pulse with 0x13, dmem_resp_o stays 0.
REQ-036 Lone D write addr 0x1000, wdata 0xDEAD_BEEF, mask 0b0011 -> downstream fields match exactly, dmem_resp_o one pulse.
REQ-037 Both valid held for 4 transactions, ARB_POLICY=1 -> grant order D,I,D,I; ARB_POLICY=0 -> D,D,D,D until D drops.
REQ-038 TIMEOUT_CYCLES=8, memory never responds -> err_o rises after 8 BUSY cycles, stays 1; later mem_resp_i completes the transfer, err_o remains 1 until reset.
REQ-039 rst_ni low in BUSY_D, then stray mem_resp_i in IDLE -> no resp pulse, mem_valid_o=0, next request granted normally.
REQ-040 Spurious mem_resp_i in IDLE and I valid dropped mid-BUSY_I -> first ignored, second still yields exactly one imem_resp_o.
